// File: rtl/aes192_key_scheduler.sv
// aes192_key_scheduler: AES-192 key expansion, one KeyGeneration192 step per cycle,
// buffering expanded words and streaming 128-bit round keys over valid/ready.
module aes192_key_scheduler #(
  parameter int NUM_RK = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [191:0] key_in,
  input  logic         abort,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         done
);
  localparam int STEPS = (4 * NUM_RK > 6) ? (4 * NUM_RK - 6 + 5) / 6 : 0;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [191:0] gen_key, gen_key_n;
  logic [31:0] wbuf [10];
  logic [31:0] buf_n [10];
  logic [31:0] kg [6];
  logic [31:0] rot, tmp;
  logic [3:0] count, count_n, rk_index_n, step_cnt, step_cnt_n, base;
  logic [2:0] rc, rc_n;
  logic done_n, pop, push, last;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  // GF(2^8) inverse as a^254 followed by the AES affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r = gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  assign key_ready = (state == IDLE);
  assign rk_valid  = (state == RUN) && (count >= 4'd4);
  assign rk_data   = {wbuf[0], wbuf[1], wbuf[2], wbuf[3]};
  always_comb begin
    rot = {gen_key[23:0], gen_key[31:24]};
    tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {8'h01 << rc, 24'h0};
    kg[0] = gen_key[191:160] ^ tmp;
    for (int i = 1; i < 6; i++) kg[i] = gen_key[191-32*i -: 32] ^ kg[i-1];
  end
  always_comb begin
    pop = rk_valid & rk_ready;
    last = pop && (rk_index == 4'(NUM_RK - 1));
    base = count - (pop ? 4'd4 : 4'd0);
    push = (state == RUN) && !abort && !last && (step_cnt < 4'(STEPS)) && (base <= 4'd4);
    state_n = state;
    gen_key_n = gen_key;
    count_n = pop ? base : count;
    rc_n = rc;
    step_cnt_n = step_cnt;
    rk_index_n = pop ? rk_index + 4'd1 : rk_index;
    done_n = 1'b0;
    for (int i = 0; i < 6; i++) buf_n[i] = pop ? wbuf[i+4] : wbuf[i];
    for (int i = 6; i < 10; i++) buf_n[i] = pop ? 32'h0 : wbuf[i];
    if (push) begin
      for (int i = 0; i < 6; i++) buf_n[base + 4'(i)] = kg[i];
      gen_key_n = {kg[0], kg[1], kg[2], kg[3], kg[4], kg[5]};
      rc_n = rc + 3'd1;
      step_cnt_n = step_cnt + 4'd1;
      count_n = base + 4'd6;
    end
    if (state == IDLE) begin
      if (key_valid) begin
        state_n = RUN;
        gen_key_n = key_in;
        for (int i = 0; i < 6; i++) buf_n[i] = key_in[191-32*i -: 32];
        count_n = 4'd6;
        rc_n = 3'd0;
        step_cnt_n = 4'd0;
        rk_index_n = 4'd0;
      end
    end else if (abort || last) begin
      state_n = IDLE;
      for (int i = 0; i < 10; i++) buf_n[i] = 32'h0;
      count_n = 4'd0;
      rk_index_n = 4'd0;
      done_n = last && !abort;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gen_key <= '0;
      for (int i = 0; i < 10; i++) wbuf[i] <= '0;
      count <= '0;
      rc <= '0;
      step_cnt <= '0;
      rk_index <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      gen_key <= gen_key_n;
      for (int i = 0; i < 10; i++) wbuf[i] <= buf_n[i];
      count <= count_n;
      rc <= rc_n;
      step_cnt <= step_cnt_n;
      rk_index <= rk_index_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_aes192_key_scheduler.sv
// tb_aes192_key_scheduler: random and FIPS-197 keys checked against a word-level
// AES-192 expansion model, plus backpressure, abort, reset and NUM_RK=11 scenarios.
module tb_aes192_key_scheduler;
  logic clk = 0, rst_n = 0;
  logic key_valid = 0, abort = 0, rk_ready = 0;
  logic [191:0] key_in = '0;
  logic key_ready, rk_valid, done;
  logic [127:0] rk_data;
  logic [3:0] rk_index;
  logic k11_valid = 0, k11_abort = 0, k11_rready = 0;
  logic [191:0] k11_key = '0;
  logic k11_kready, k11_rvalid, k11_done;
  logic [127:0] k11_data;
  logic [3:0] k11_index;
  int checks = 0, errors = 0;
  logic [7:0] ex [256];
  logic [7:0] lg [256];
  logic [127:0] exp_rk [13];

  aes192_key_scheduler dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .abort(abort), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_index(rk_index), .done(done));
  aes192_key_scheduler #(.NUM_RK(11)) dut11 (
    .clk(clk), .rst_n(rst_n), .key_valid(k11_valid), .key_ready(k11_kready), .key_in(k11_key),
    .abort(k11_abort), .rk_valid(k11_rvalid), .rk_ready(k11_rready), .rk_data(k11_data),
    .rk_index(k11_index), .done(k11_done));

  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] model_sbox(input logic [7:0] x);
    logic [7:0] inv, s, c;
    c = 8'h63;
    inv = (x == 0) ? 8'h00 : ex[(255 - int'(lg[x])) % 255];
    for (int b = 0; b < 8; b++)
      s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
    return s;
  endfunction
  task automatic build_tables();
    logic [7:0] e;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = e;
      lg[e] = 8'(i);
      e = e ^ xtime(e);
    end
  endtask
  task automatic build_model(input logic [191:0] k);
    logic [31:0] w [52];
    logic [31:0] t;
    for (int i = 0; i < 6; i++) w[i] = k[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {model_sbox(t[31:24]), model_sbox(t[23:16]), model_sbox(t[15:8]), model_sbox(t[7:0])};
        t = t ^ (32'h01000000 << (i / 6 - 1));
      end
      w[i] = w[i-6] ^ t;
    end
    for (int r = 0; r < 13; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  function automatic logic [191:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic load_key(input logic [191:0] k);
    @(negedge clk);
    key_in = k;
    key_valid = 1;
    @(negedge clk);
    key_valid = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 5;
    if (key_ready !== 1'b1) begin errors++; $display("FAIL reset key_ready: got %b want 1", key_ready); end
    if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset rk_valid: got %b want 0", rk_valid); end
    if (rk_data !== 128'h0) begin errors++; $display("FAIL reset rk_data: got %h want 0", rk_data); end
    if (rk_index !== 4'd0) begin errors++; $display("FAIL reset rk_index: got %0d want 0", rk_index); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin errors++; $display("FAIL post-reset idle: ready %b valid %b want 1 0", key_ready, rk_valid); end
  endtask

  task automatic test_fips(input logic [191:0] k, input logic [127:0] rk1, input logic [127:0] rk12, input string name);
    build_model(k);
    load_key(k);
    for (int r = 0; r < 13; r++) begin
      checks += 4;
      if (rk_valid !== 1'b1) begin errors++; $display("FAIL %s valid r%0d: got %b want 1", name, r, rk_valid); end
      if (rk_index !== 4'(r)) begin errors++; $display("FAIL %s index: got %0d want %0d", name, rk_index, r); end
      if (rk_data !== exp_rk[r]) begin errors++; $display("FAIL %s rk%0d: got %h want %h", name, r, rk_data, exp_rk[r]); end
      if (done !== 1'b0) begin errors++; $display("FAIL %s early done at r%0d", name, r); end
      if (r == 0) begin checks++; if (rk_data !== k[191:64]) begin errors++; $display("FAIL %s rk0 literal: got %h want %h", name, rk_data, k[191:64]); end end
      if (r == 1 && rk1 !== 128'h0) begin checks++; if (rk_data !== rk1) begin errors++; $display("FAIL %s rk1 literal: got %h want %h", name, rk_data, rk1); end end
      if (r == 12) begin checks++; if (rk_data !== rk12) begin errors++; $display("FAIL %s rk12 literal: got %h want %h", name, rk_data, rk12); end end
      rk_ready = 1;
      @(negedge clk);
    end
    checks += 3;
    if (done !== 1'b1) begin errors++; $display("FAIL %s done pulse: got %b want 1", name, done); end
    if (key_ready !== 1'b1) begin errors++; $display("FAIL %s key_ready at end: got %b want 1", name, key_ready); end
    if (rk_valid !== 1'b0) begin errors++; $display("FAIL %s valid at end: got %b want 0", name, rk_valid); end
    rk_ready = 0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done width: got %b want 0", name, done); end
  endtask

  task automatic test_backpressure();
    logic [127:0] prev_data;
    logic [3:0] prev_idx;
    logic stalled, rdy;
    int r, cyc;
    for (int n = 0; n < 3; n++) begin
      build_model(rand_key());
      load_key({exp_rk[0], exp_rk[1][127:64]});
      r = 0; cyc = 0; stalled = 0;
      while (r < 13 && cyc < 400) begin
        checks += 2;
        if (dut.count > 4'd10) begin errors++; $display("FAIL bp count: got %0d want <=10", dut.count); end
        if (rk_valid !== 1'b1) begin errors++; $display("FAIL bp valid dropped: got %b want 1", rk_valid); end
        if (stalled) begin
          checks++;
          if (rk_data !== prev_data || rk_index !== prev_idx) begin errors++; $display("FAIL bp stall stability: got %h/%0d want %h/%0d", rk_data, rk_index, prev_data, prev_idx); end
        end
        rdy = ($urandom_range(0, 99) < 30);
        rk_ready = rdy;
        if (rdy) begin
          checks += 2;
          if (rk_index !== 4'(r)) begin errors++; $display("FAIL bp index: got %0d want %0d", rk_index, r); end
          if (rk_data !== exp_rk[r]) begin errors++; $display("FAIL bp rk%0d: got %h want %h", r, rk_data, exp_rk[r]); end
          r++;
        end
        stalled = !rdy;
        prev_data = rk_data;
        prev_idx = rk_index;
        cyc++;
        @(negedge clk);
      end
      rk_ready = 0;
      checks += 2;
      if (r != 13) begin errors++; $display("FAIL bp timeout: got %0d keys want 13", r); end
      if (done !== 1'b1) begin errors++; $display("FAIL bp done: got %b want 1", done); end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    build_model(rand_key());
    load_key({exp_rk[0], exp_rk[1][127:64]});
    rk_ready = 1;
    for (int r = 0; r < 6; r++) @(negedge clk);
    checks++;
    if (rk_index !== 4'd6) begin errors++; $display("FAIL abort pre index: got %0d want 6", rk_index); end
    abort = 1;
    @(negedge clk);
    abort = 0;
    rk_ready = 0;
    checks += 3;
    if (rk_valid !== 1'b0) begin errors++; $display("FAIL abort valid: got %b want 0", rk_valid); end
    if (key_ready !== 1'b1) begin errors++; $display("FAIL abort key_ready: got %b want 1", key_ready); end
    if (done !== 1'b0) begin errors++; $display("FAIL abort done: got %b want 0", done); end
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("FAIL abort late done: got %b want 0", done); end
    if (key_ready !== 1'b1) begin errors++; $display("FAIL abort idle effect: got %b want 1", key_ready); end
    build_model(rand_key());
    load_key({exp_rk[0], exp_rk[1][127:64]});
    checks += 2;
    if (rk_index !== 4'd0) begin errors++; $display("FAIL abort restart index: got %0d want 0", rk_index); end
    if (rk_data !== exp_rk[0]) begin errors++; $display("FAIL abort restart rk0: got %h want %h", rk_data, exp_rk[0]); end
    abort = 1;
    @(negedge clk);
    abort = 0;
  endtask

  task automatic test_reset_mid_run();
    logic [191:0] other;
    build_model(rand_key());
    load_key({exp_rk[0], exp_rk[1][127:64]});
    other = rand_key();
    rk_ready = 1;
    @(negedge clk);
    @(negedge clk);
    rk_ready = 0;
    key_in = other;
    key_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 3;
      if (key_ready !== 1'b0) begin errors++; $display("FAIL run key_ready: got %b want 0", key_ready); end
      if (rk_index !== 4'd2) begin errors++; $display("FAIL run hold index: got %0d want 2", rk_index); end
      if (rk_data !== exp_rk[2]) begin errors++; $display("FAIL run key not latched: got %h want %h", rk_data, exp_rk[2]); end
    end
    #2 rst_n = 0;
    #1;
    checks += 5;
    if (key_ready !== 1'b1) begin errors++; $display("FAIL async key_ready: got %b want 1", key_ready); end
    if (rk_valid !== 1'b0) begin errors++; $display("FAIL async rk_valid: got %b want 0", rk_valid); end
    if (rk_data !== 128'h0) begin errors++; $display("FAIL async rk_data: got %h want 0", rk_data); end
    if (rk_index !== 4'd0) begin errors++; $display("FAIL async rk_index: got %0d want 0", rk_index); end
    if (done !== 1'b0) begin errors++; $display("FAIL async done: got %b want 0", done); end
    key_valid = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rk_valid !== 1'b0) begin errors++; $display("FAIL post-reset valid: got %b want 0", rk_valid); end
    end
  endtask

  task automatic test_num_rk11();
    build_model(rand_key());
    @(negedge clk);
    k11_key = {exp_rk[0], exp_rk[1][127:64]};
    k11_valid = 1;
    @(negedge clk);
    k11_valid = 0;
    for (int r = 0; r < 11; r++) begin
      checks += 4;
      if (k11_rvalid !== 1'b1) begin errors++; $display("FAIL rk11 valid r%0d: got %b want 1", r, k11_rvalid); end
      if (k11_index !== 4'(r)) begin errors++; $display("FAIL rk11 index: got %0d want %0d", k11_index, r); end
      if (k11_data !== exp_rk[r]) begin errors++; $display("FAIL rk11 rk%0d: got %h want %h", r, k11_data, exp_rk[r]); end
      if (k11_done !== 1'b0) begin errors++; $display("FAIL rk11 early done r%0d", r); end
      k11_rready = 1;
      @(negedge clk);
    end
    k11_rready = 0;
    checks += 2;
    if (k11_done !== 1'b1) begin errors++; $display("FAIL rk11 done: got %b want 1", k11_done); end
    if (k11_kready !== 1'b1) begin errors++; $display("FAIL rk11 idle: got %b want 1", k11_kready); end
    @(negedge clk);
  endtask

  initial begin
    build_tables();
    test_reset();
    test_fips(192'h000102030405060708090a0b0c0d0e0f1011121314151617,
              128'h10111213141516175846f2f95c43f4fe,
              128'ha4970a331a78dc09c418c271e3a41d5d, "c2");
    test_fips(192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 128'h0,
              128'he98ba06f448c773c8ecc720401002202, "a2");
    test_backpressure();
    test_abort();
    test_reset_mid_run();
    test_num_rk11();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
